// File: rtl/rx_pt_pkg.sv
// Shared definitions for the RX-initiated point test initiator: FSM states,
// sideband message codes and mainband comparator control words.
package rx_pt_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SEND_START,
      WAIT_START,
      SEND_CLR,
      WAIT_CLR,
      COMPARE,
      SEND_DONE_RESP,
      SEND_END,
      WAIT_END,
      DONE
   } state_t;

   localparam logic [3:0] MSG_START_REQ    = 4'd1;
   localparam logic [3:0] MSG_START_RESP   = 4'd2;
   localparam logic [3:0] MSG_CLR_REQ      = 4'd3;
   localparam logic [3:0] MSG_CLR_RESP     = 4'd4;
   localparam logic [3:0] MSG_TX_DONE_REQ  = 4'd5;
   localparam logic [3:0] MSG_TX_DONE_RESP = 4'd6;
   localparam logic [3:0] MSG_END_REQ      = 4'd7;
   localparam logic [3:0] MSG_END_RESP     = 4'd8;

   localparam logic [1:0] CW_OFF      = 2'b00;
   localparam logic [1:0] CW_CLEAR    = 2'b01;
   localparam logic [1:0] CW_LFSR     = 2'b10;
   localparam logic [1:0] CW_PER_LANE = 2'b11;

endpackage

// File: rtl/rx_initiated_point_test_initiator.sv
// Sideband handshake sequencer for an RX-initiated point test with result latching.
// Optional comparison-phase timeout is enabled by defining RX_PT_TIMEOUT_EN.
module rx_initiated_point_test_initiator
   import rx_pt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 800000,
   parameter int CNT_W          = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic        i_mainband_or_valtrain_test,
   input  logic        i_lfsr_or_perlane,
   input  logic [3:0]  i_sideband_message,
   input  logic        i_sideband_message_valid,
   input  logic        i_falling_edge_busy,
   input  logic [15:0] i_comparison_results,
   input  logic        i_valid_result,
   output logic [3:0]  o_sideband_message,
   output logic        o_valid,
   output logic [15:0] o_sideband_data,
   output logic        o_data_valid,
   output logic [1:0]  o_mainband_pattern_compartor_cw,
   output logic        o_comparison_valid_en,
   output logic        o_test_ack,
   output logic [15:0] o_mainband_lanes_result,
   output logic        o_valid_result
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
   end

   state_t state;
   state_t next_state;

   logic got_tx_done;
   logic timed_out;

   assign got_tx_done = i_sideband_message_valid && (i_sideband_message == MSG_TX_DONE_REQ);

`ifdef RX_PT_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;

   assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in COMPARE; any other state (or leaving COMPARE) clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == COMPARE && next_state == COMPARE) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Dropping i_en overrides every handshake step so the test can be aborted anywhere.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:           if (i_en) next_state = SEND_START;
         SEND_START:     if (i_falling_edge_busy) next_state = WAIT_START;
         WAIT_START:     if (i_sideband_message_valid && i_sideband_message == MSG_START_RESP)
                            next_state = SEND_CLR;
         SEND_CLR:       if (i_falling_edge_busy) next_state = WAIT_CLR;
         WAIT_CLR:       if (i_sideband_message_valid && i_sideband_message == MSG_CLR_RESP)
                            next_state = COMPARE;
         COMPARE: begin
            if (got_tx_done) begin
               next_state = SEND_DONE_RESP;
            end else if (timed_out) begin
               next_state = DONE;
            end
         end
         SEND_DONE_RESP: if (i_falling_edge_busy) next_state = SEND_END;
         SEND_END:       if (i_falling_edge_busy) next_state = WAIT_END;
         WAIT_END:       if (i_sideband_message_valid && i_sideband_message == MSG_END_RESP)
                            next_state = DONE;
         DONE:           next_state = DONE;
         default:        next_state = IDLE;
      endcase
      if (state != IDLE && !i_en) begin
         next_state = IDLE;
      end
   end

   always_comb begin
      o_sideband_message              = 4'd0;
      o_valid                         = 1'b0;
      o_sideband_data                 = 16'd0;
      o_data_valid                    = 1'b0;
      o_mainband_pattern_compartor_cw = CW_OFF;
      o_comparison_valid_en           = 1'b0;
      o_test_ack                      = 1'b0;
      case (state)
         SEND_START: begin
            o_valid            = 1'b1;
            o_sideband_message = MSG_START_REQ;
            o_sideband_data    = {14'd0, i_mainband_or_valtrain_test, i_lfsr_or_perlane};
            o_data_valid       = 1'b1;
         end
         SEND_CLR: begin
            o_valid                         = 1'b1;
            o_sideband_message              = MSG_CLR_REQ;
            o_mainband_pattern_compartor_cw = CW_CLEAR;
         end
         WAIT_CLR: o_mainband_pattern_compartor_cw = CW_CLEAR;
         COMPARE: begin
            if (i_mainband_or_valtrain_test) begin
               o_comparison_valid_en = 1'b1;
            end else begin
               o_mainband_pattern_compartor_cw = i_lfsr_or_perlane ? CW_PER_LANE : CW_LFSR;
            end
         end
         SEND_DONE_RESP: begin
            o_valid            = 1'b1;
            o_sideband_message = MSG_TX_DONE_RESP;
         end
         SEND_END: begin
            o_valid            = 1'b1;
            o_sideband_message = MSG_END_REQ;
         end
         DONE:    o_test_ack = 1'b1;
         default: ;
      endcase
   end

   // Results persist through aborts; only a new test start or a timeout clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_mainband_lanes_result <= 16'd0;
         o_valid_result          <= 1'b0;
      end else if (state == IDLE && i_en) begin
         o_mainband_lanes_result <= 16'd0;
         o_valid_result          <= 1'b0;
      end else if (state == COMPARE && next_state == SEND_DONE_RESP) begin
         o_mainband_lanes_result <= i_mainband_or_valtrain_test ? 16'd0 : i_comparison_results;
         o_valid_result          <= i_mainband_or_valtrain_test ? i_valid_result : 1'b0;
      end else if (state == COMPARE && next_state == DONE) begin
         o_mainband_lanes_result <= 16'd0;
         o_valid_result          <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_initiated_point_test_initiator.sv
// Self-checking bench: a protocol-script model is compared every cycle,
// plus directed scenarios with literal expectations and a random soak.
module tb_rx_initiated_point_test_initiator;

   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, mb, lf, sv, busy, vres_in;
   logic [3:0]  msg;
   logic [15:0] cmp_res;
   logic [3:0]  o_msg;
   logic        o_valid, o_dv, o_ven, o_ack, o_vres;
   logic [15:0] o_data, o_lanes;
   logic [1:0]  o_cw;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   rx_initiated_point_test_initiator #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(20)) dut (
      .clk(clk), .rst(rst), .i_en(en),
      .i_mainband_or_valtrain_test(mb), .i_lfsr_or_perlane(lf),
      .i_sideband_message(msg), .i_sideband_message_valid(sv),
      .i_falling_edge_busy(busy), .i_comparison_results(cmp_res),
      .i_valid_result(vres_in),
      .o_sideband_message(o_msg), .o_valid(o_valid), .o_sideband_data(o_data),
      .o_data_valid(o_dv), .o_mainband_pattern_compartor_cw(o_cw),
      .o_comparison_valid_en(o_ven), .o_test_ack(o_ack),
      .o_mainband_lanes_result(o_lanes), .o_valid_result(o_vres)
   );

   // Protocol script: step -1 idle, 0..7 walk the handshake, 8 finished.
   // Steps 0,2,5,6 send a code; 1,3,7 wait for a code; 4 is the comparison window.
   int          step;
   int          cmpCycles;
   logic [15:0] mLanes;
   logic        mVres;

   function automatic logic [3:0] sendCode(input int s);
      case (s)
         0: return 4'd1;
         2: return 4'd3;
         5: return 4'd6;
         6: return 4'd7;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] waitCode(input int s);
      case (s)
         1: return 4'd2;
         3: return 4'd4;
         4: return 4'd5;
         7: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         step = -1; cmpCycles = 0; mLanes = 16'd0; mVres = 1'b0;
      end else if (step == -1) begin
         if (en) begin
            step = 0; mLanes = 16'd0; mVres = 1'b0;
         end
      end else if (!en) begin
         step = -1;
      end else if (sendCode(step) != 4'd0) begin
         if (busy) step = step + 1;
      end else if (step == 4) begin
         if (sv && msg == 4'd5) begin
            mLanes = mb ? 16'd0 : cmp_res;
            mVres  = mb ? vres_in : 1'b0;
            step   = 5;
         end else begin
            cmpCycles = cmpCycles + 1;
`ifdef RX_PT_TIMEOUT_EN
            if (cmpCycles >= TIMEOUT) begin
               step = 8; mLanes = 16'd0; mVres = 1'b0;
            end
`endif
         end
      end else if (step != 8) begin
         if (sv && msg == waitCode(step)) begin
            step = step + 1;
            if (step == 4) cmpCycles = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      else
         passCount++;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("model_valid", 32'(o_valid), 32'(sendCode(step) != 4'd0));
         checkOutput("model_code",  32'(o_msg),   32'(sendCode(step)));
         checkOutput("model_data",  32'(o_data),  (step == 0) ? 32'({mb, lf}) : 32'd0);
         checkOutput("model_dv",    32'(o_dv),    32'(step == 0));
         checkOutput("model_cw",    32'(o_cw),
                     (step == 2 || step == 3) ? 32'd1 :
                     (step == 4 && !mb) ? (lf ? 32'd3 : 32'd2) : 32'd0);
         checkOutput("model_ven",   32'(o_ven),   32'(step == 4 && mb));
         checkOutput("model_ack",   32'(o_ack),   32'(step == 8));
         checkOutput("model_lanes", 32'(o_lanes), 32'(mLanes));
         checkOutput("model_vres",  32'(o_vres),  32'(mVres));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sendMsg(input logic [3:0] code);
      sv = 1'b1; msg = code;
      tick();
      sv = 1'b0; msg = 4'd0;
   endtask

   task automatic pulseBusy(input int n);
      busy = 1'b1;
      repeat (n) tick();
      busy = 1'b0;
   endtask

   // Randomized soak: responses are drawn around what the script expects next.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         cmp_res = 16'($urandom);
         vres_in = 1'($urandom);
         busy    = ($urandom_range(0, 2) == 0);
         sv      = ($urandom_range(0, 1) == 1);
         if (step == -1) begin
            if (!en) begin
               mb = 1'($urandom);
               lf = 1'($urandom);
            end
            en = ($urandom_range(0, 3) != 0);
         end else if (step == 8) begin
            en = ($urandom_range(0, 2) != 0);
         end else begin
            en = ($urandom_range(0, 79) != 0);
         end
         if (waitCode(step) != 4'd0 && $urandom_range(0, 1) == 1)
            msg = waitCode(step);
         else
            msg = 4'($urandom_range(0, 15));
         tick();
      end
      en = 1'b0; sv = 1'b0; busy = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mb = 1'b0; lf = 1'b0; sv = 1'b0; busy = 1'b0;
      vres_in = 1'b0; msg = 4'd0; cmp_res = 16'd0;
      #7;
      checkOutput("reset_valid", 32'(o_valid), 32'd0);
      checkOutput("reset_cw",    32'(o_cw),    32'd0);
      checkOutput("reset_ack",   32'(o_ack),   32'd0);
      checkOutput("reset_lanes", 32'(o_lanes), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Mainband LFSR test, busy withheld, wrong response code, then full handshake.
      en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_valid", 32'(o_valid), 32'd1);
         checkOutput("hold_code",  32'(o_msg),   32'd1);
         tick();
      end
      pulseBusy(1);
      sendMsg(4'd4);
      checkOutput("wrong_code_valid", 32'(o_valid), 32'd0);
      checkOutput("wrong_code_msg",   32'(o_msg),   32'd0);
      sendMsg(4'd2);
      checkOutput("clr_code", 32'(o_msg), 32'd3);
      checkOutput("clr_cw",   32'(o_cw),  32'd1);
      pulseBusy(1);
      sendMsg(4'd4);
      checkOutput("lfsr_cw", 32'(o_cw), 32'd2);
      cmp_res = 16'hFFF0; vres_in = 1'b1;
      sendMsg(4'd5);
      checkOutput("done_resp_code", 32'(o_msg), 32'd6);
      pulseBusy(2);
      sendMsg(4'd8);
      checkOutput("mb_ack",   32'(o_ack),   32'd1);
      checkOutput("mb_lanes", 32'(o_lanes), 32'hFFF0);
      checkOutput("mb_vres",  32'(o_vres),  32'd0);
      en = 1'b0;
      tick();
      checkOutput("idle_ack",      32'(o_ack),   32'd0);
      checkOutput("idle_retained", 32'(o_lanes), 32'hFFF0);

      // Valid-train test.
      mb = 1'b1; lf = 1'b0; en = 1'b1;
      tick();
      checkOutput("vt_start_data", 32'(o_data), 32'h0002);
      checkOutput("vt_start_dv",   32'(o_dv),   32'd1);
      checkOutput("vt_cleared",    32'(o_lanes), 32'd0);
      pulseBusy(1);
      sendMsg(4'd2);
      pulseBusy(1);
      sendMsg(4'd4);
      checkOutput("vt_cw",  32'(o_cw),  32'd0);
      checkOutput("vt_ven", 32'(o_ven), 32'd1);
      cmp_res = 16'hABCD; vres_in = 1'b1;
      sendMsg(4'd5);
      pulseBusy(2);
      sendMsg(4'd8);
      checkOutput("vt_ack",   32'(o_ack),   32'd1);
      checkOutput("vt_vres",  32'(o_vres),  32'd1);
      checkOutput("vt_lanes", 32'(o_lanes), 32'd0);
      en = 1'b0;
      tick();

      // Per-lane test aborted during comparison.
      mb = 1'b0; lf = 1'b1; en = 1'b1;
      tick();
      pulseBusy(1);
      sendMsg(4'd2);
      pulseBusy(1);
      sendMsg(4'd4);
      checkOutput("perlane_cw", 32'(o_cw), 32'd3);
      checkOutput("abort_vres_cleared", 32'(o_vres), 32'd0);
      en = 1'b0;
      tick();
      checkOutput("abort_cw",    32'(o_cw),    32'd0);
      checkOutput("abort_valid", 32'(o_valid), 32'd0);
      checkOutput("abort_ack",   32'(o_ack),   32'd0);

      // Comparison window with no TX_DONE_REQ.
      mb = 1'b0; lf = 1'b0; en = 1'b1;
      tick();
      pulseBusy(1);
      sendMsg(4'd2);
      pulseBusy(1);
      sendMsg(4'd4);
      repeat (TIMEOUT - 1) tick();
      checkOutput("pre_timeout_ack", 32'(o_ack), 32'd0);
      tick();
`ifdef RX_PT_TIMEOUT_EN
      checkOutput("timeout_ack",   32'(o_ack),   32'd1);
      checkOutput("timeout_lanes", 32'(o_lanes), 32'd0);
`else
      repeat (50) tick();
      checkOutput("no_timeout_ack", 32'(o_ack), 32'd0);
      checkOutput("no_timeout_cw",  32'(o_cw),  32'd2);
`endif
      en = 1'b0;
      tick();

      // Asynchronous reset in the middle of a test.
      en = 1'b1;
      tick();
      pulseBusy(1);
      sendMsg(4'd2);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(o_valid), 32'd0);
      checkOutput("async_rst_cw",    32'(o_cw),    32'd0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();

      applyStimulus(4000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/rx_initiated_point_test_initiator.md
RX_INITIATED_POINT_TEST_INITIATOR -- requirements
Module: rx_initiated_point_test_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 800000, comparison-phase timeout (8 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, timeout counter width; TIMEOUT_CYCLES < 2^CNT_W.
REQ-003 SHALL have ports, one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- i_en  in  1  start test (level); deassert aborts
- i_mainband_or_valtrain_test  in  1  0 mainband, 1 valid-train
- i_lfsr_or_perlane  in  1  0 LFSR, 1 per-lane
- i_sideband_message  in  4  received message code
- i_sideband_message_valid  in  1  receive strobe
- i_falling_edge_busy  in  1  sideband TX accepted current message
- i_comparison_results  in  16  per-lane pass(1)/fail(0) from mainband comparators
- i_valid_result  in  1  valid-lane comparator pass
- o_sideband_message  out  4  message code to send
- o_valid  out  1  send request
- o_sideband_data  out  16  message data
- o_data_valid  out  1  o_sideband_data meaningful
- o_mainband_pattern_compartor_cw  out  2  00 off, 01 clear, 10 LFSR, 11 per-lane
- o_comparison_valid_en  out  1  enable valid-lane comparator
- o_test_ack  out  1  test complete
- o_mainband_lanes_result  out  16  latched lane result
- o_valid_result  out  1  latched valid-lane result

Function
REQ-004 SHALL implement FSM IDLE, SEND_START, WAIT_START, SEND_CLR, WAIT_CLR, COMPARE, SEND_DONE_RESP, SEND_END, WAIT_END, DONE.
REQ-005 IDLE->SEND_START SHALL occur the cycle after i_en sampled high.
REQ-006 In every SEND_* state o_valid SHALL be 1 with the state's code held stable until i_falling_edge_busy is sampled high, then advance next cycle; o_valid low in all other states.
REQ-007 Codes SHALL be: START_REQ 1, START_RESP 2, CLR_REQ 3, CLR_RESP 4, TX_DONE_REQ 5, TX_DONE_RESP 6, END_REQ 7, END_RESP 8.
REQ-008 SEND_START SHALL drive o_sideband_data = {14'b0, i_mainband_or_valtrain_test, i_lfsr_or_perlane} with o_data_valid=1; other SEND_* states SHALL drive data 0, o_data_valid=0.
REQ-009 WAIT_* states SHALL advance only on i_sideband_message_valid with the matching response code; all other codes ignored.
REQ-010 cw SHALL be 01 in SEND_CLR/WAIT_CLR; in COMPARE 10 (LFSR) or 11 (per-lane) for mainband test, 00 for valid-train test; 00 elsewhere.
REQ-011 o_comparison_valid_en SHALL be 1 only in COMPARE with valid-train test selected.
REQ-012 COMPARE SHALL exit to SEND_DONE_RESP on received TX_DONE_REQ, latching i_comparison_results (0 for valid-train test) and i_valid_result (0 for mainband test) that cycle.
REQ-013 o_test_ack SHALL be 1 only in DONE; DONE->IDLE when i_en low.
REQ-014 i_en low in any non-IDLE state SHALL force IDLE next cycle, clear o_valid, cw, enables; latched results retained.
REQ-015 Results SHALL clear on entry to SEND_START.
REQ-016 Receive strobe and busy falling edge in the same cycle SHALL be processed independently per current state.

Reset
REQ-017 rst SHALL force IDLE and all outputs 0 asynchronously; release synchronous to clk.

Configuration
REQ-018 With RX_PT_TIMEOUT_EN defined, a counter SHALL run in COMPARE; reaching TIMEOUT_CYCLES SHALL go to DONE with results all-0 and o_test_ack=1; counter cleared outside COMPARE.
REQ-019 Without RX_PT_TIMEOUT_EN, COMPARE SHALL wait indefinitely; no counter logic.

Structure
REQ-020 Message codes, cw encodings and state enum SHALL live in package rx_pt_pkg.
REQ-021 No sub-module; single FSM with output decode.

Verification
REQ-022 Mainband LFSR, full handshake, TX_DONE_REQ with results 16'hFFF0 -> o_mainband_lanes_result=16'hFFF0, o_test_ack=1.
REQ-023 Valid-train test -> START data 16'h0002, cw stays 00 in COMPARE, o_comparison_valid_en=1, o_valid_result matches i_valid_result.
REQ-024 Busy falling edge withheld 10 cycles in SEND_START -> o_valid and code 1 held stable 10 cycles.
REQ-025 Wrong code (4) in WAIT_START -> no transition; code 2 then advances.
REQ-026 i_en dropped in COMPARE -> IDLE next cycle, cw=00, o_valid=0.
REQ-027 RX_PT_TIMEOUT_EN, TIMEOUT_CYCLES=100, no TX_DONE_REQ -> o_test_ack after 100 COMPARE cycles, result 0.
